// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: FETCH/DECODE/EXEC/WB sequencer feeding the 16-bit ALU/regfile datapath.
// Optional macro ILLEGAL_TRAP_EN: an illegal encoding sets the sticky illegal flag and parks in HALT until reset.
module fetch_decode_ctrl #(
  parameter int                WIDTH    = 16,
  parameter int                REGBITS  = 4,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [3:0]         opcode,
  output logic [3:0]         opext,
  output logic [REGBITS-1:0] ra1,
  output logic [REGBITS-1:0] ra2,
  output logic [REGBITS-1:0] wa,
  output logic               regwrite,
  output logic               use_imm,
  output logic [WIDTH-1:0]   imm,
  output logic [ADDR_W-1:0]  pc,
  output logic               retired,
  output logic               illegal,
  output logic [2:0]         dbg_state
);

  // Handshake: mem_req stays high with mem_addr stable until a cycle where
  // mem_req & mem_ack are both 1; mem_rdata is captured in that same cycle.
`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] ir;
  logic             writes_q;
  logic [3:0]       func;
  logic             dec_imm;
  logic             dec_legal;
  logic             dec_signed;
  logic             dec_writes;
  logic [WIDTH-1:0] dec_imm_val;

  assign mem_addr  = pc;
  assign dbg_state = state;

  // The ALU function lives in opext for register form and in opcode for immediate form.
  always_comb begin
    dec_imm    = (ir[15:12] != 4'h0);
    func       = dec_imm ? ir[15:12] : ir[7:4];
    dec_legal  = 1'b0;
    dec_signed = 1'b0;
    case (func)
      4'h1, 4'h2, 4'h3, 4'hD: dec_legal = 1'b1;
      4'h5, 4'h9, 4'hB: begin
        dec_legal  = 1'b1;
        dec_signed = 1'b1;
      end
      default: ;
    endcase
    dec_writes  = dec_legal && (func != 4'hB);
    dec_imm_val = dec_signed ? {{(WIDTH-8){ir[7]}}, ir[7:0]}
                             : {{(WIDTH-8){1'b0}}, ir[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      mem_req  <= 1'b0;
      opcode   <= '0;
      opext    <= '0;
      ra1      <= '0;
      ra2      <= '0;
      wa       <= '0;
      use_imm  <= 1'b0;
      imm      <= '0;
      writes_q <= 1'b0;
      regwrite <= 1'b0;
      retired  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal  <= 1'b0;
`endif
    end else begin
      regwrite <= 1'b0;
      retired  <= 1'b0;
      case (state)
        S_FETCH: begin
          if (mem_req && mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc + ADDR_W'(1);
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end else if (run) begin
            mem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          opcode   <= ir[15:12];
          opext    <= ir[7:4];
          ra1      <= ir[11:8];
          ra2      <= ir[3:0];
          wa       <= ir[11:8];
          use_imm  <= dec_imm;
          imm      <= dec_imm_val;
          writes_q <= dec_writes;
`ifdef ILLEGAL_TRAP_EN
          if (!dec_legal) illegal <= 1'b1;
`endif
          state    <= S_EXEC;
        end
        S_EXEC: begin
          regwrite <= writes_q;
          retired  <= 1'b1;
          state    <= S_WB;
        end
        S_WB: begin
          // run is looked at here too so the next request can be acked in the first FETCH cycle.
`ifdef ILLEGAL_TRAP_EN
          if (illegal) begin
            state <= S_HALT;
          end else begin
            state   <= S_FETCH;
            mem_req <= run;
          end
`else
          state   <= S_FETCH;
          mem_req <= run;
`endif
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

`ifndef ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

endmodule
